// File: rtl/key_schedule_ctrl_if.sv
// Bus bundle for key_schedule_ctrl: key load handshake, status flags,
// round-key read port and a small debug view of the sequencer state.
//
// Handshake: a key transfers on a rising edge where key_valid and key_ready
// are both high. The sender holds key_valid and key_in stable until then.
// key_ready never depends on key_valid in the same cycle.
interface key_schedule_ctrl_if;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         dbg_expand;
    logic [3:0]   dbg_round_cnt;
    logic [7:0]   dbg_rc;

    modport master (
        output key_valid, key_in, rk_rd_en, rk_rd_idx,
        input  key_ready, busy, done, keys_valid, rk_rd_data,
        input  dbg_expand, dbg_round_cnt, dbg_rc
    );

    modport slave (
        input  key_valid, key_in, rk_rd_en, rk_rd_idx,
        output key_ready, busy, done, keys_valid, rk_rd_data,
        output dbg_expand, dbg_round_cnt, dbg_rc
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer. Loads a cipher key, runs one
// key_expansion step per clock for ten rounds, and keeps all eleven round
// keys in a register file readable through a registered port.
module key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic clk,
    input  logic rst_n,
    key_schedule_ctrl_if.slave bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, EXPAND = 1'b1} state_t;

    state_t       state;
    logic         key_ready_r;
    logic         busy_r;
    logic         done_r;
    logic         keys_valid_r;
    logic [127:0] rd_data_r;
    logic [3:0]   round_cnt;
    logic [7:0]   rc;
    logic [127:0] cur_key;
    logic [127:0] next_key;
    logic         accept;
    logic [127:0] rk_mem [0:NUM_ROUNDS];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box computed as inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] y;
        logic [7:0] s;
        t = x;
        y = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            y = gf_mul(y, t);
        end
        s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
        return s;
    endfunction

    // One AES-128 round-key step; byte 0 of each word sits in its low bits.
    function automatic logic [127:0] key_expansion(input logic [127:0] k, input logic [31:0] rcon);
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        t  = {sub_byte(k[103:96]), sub_byte(k[127:120]), sub_byte(k[119:112]), sub_byte(k[111:104])} ^ rcon;
        n0 = k[31:0]   ^ t;
        n1 = k[63:32]  ^ n0;
        n2 = k[95:64]  ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    assign accept   = bus.key_valid & key_ready_r;
    assign next_key = key_expansion(cur_key, {24'h0, rc});

    // Sequencer: accept a key in IDLE, then one expansion round per clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            key_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            keys_valid_r <= 1'b0;
            round_cnt    <= 4'd0;
            rc           <= 8'h01;
            cur_key      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= EXPAND;
                        key_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        keys_valid_r <= 1'b0;
                        cur_key      <= bus.key_in;
                        round_cnt    <= 4'd1;
                        rc           <= 8'h01;
                    end
                end
                EXPAND: begin
                    cur_key <= next_key;
                    rc      <= xtime(rc);
                    if (round_cnt == 4'(NUM_ROUNDS)) begin
                        // Last round: round_cnt parks at its final value.
                        state        <= IDLE;
                        key_ready_r  <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        keys_valid_r <= 1'b1;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Round-key storage: slot 0 on accept, slot round_cnt during expansion.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == IDLE && accept) begin
                rk_mem[0] <= bus.key_in;
            end else if (state == EXPAND) begin
                rk_mem[round_cnt] <= next_key;
            end
        end
    end

    // Registered read port; sees pre-edge contents when a write hits the same slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r <= '0;
        end else if (bus.rk_rd_en) begin
            if (bus.rk_rd_idx <= 4'(NUM_ROUNDS)) rd_data_r <= rk_mem[bus.rk_rd_idx];
            else                                 rd_data_r <= '0;
        end
    end

    assign bus.key_ready     = key_ready_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.keys_valid    = keys_valid_r;
    assign bus.rk_rd_data    = rd_data_r;
    assign bus.dbg_expand    = (state == EXPAND);
    assign bus.dbg_round_cnt = round_cnt;
    assign bus.dbg_rc        = rc;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: a byte-level AES-128 key schedule model
// built from first principles supplies every expected round key.
module tb_key_schedule_ctrl;

    logic clk;
    logic rst_n;

    key_schedule_ctrl_if bus ();

    key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   rcon_tab [1:10];
    logic [7:0]   rc_seen  [1:10];
    logic [127:0] exp_rk   [0:10];
    logic [127:0] prev_rk  [0:10];
    logic [127:0] exp_q    [$];

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[8*n +: 8] = v[8*(15-n) +: 8];
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] xb;
        logic [7:0] yb;
        logic [7:0] r;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            rcon_tab[k] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    // FIPS-197 word recurrence over a flat byte array w[0..175].
    task automatic model_expand(input logic [127:0] key);
        logic [7:0] b [176];
        logic [7:0] t [4];
        logic [7:0] tmp;
        for (int n = 0; n < 16; n++) b[n] = key[8*n +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = b[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp  = t[0];
                t[0] = sbox[t[1]] ^ rcon_tab[i/4];
                t[1] = sbox[t[2]];
                t[2] = sbox[t[3]];
                t[3] = sbox[tmp];
            end
            for (int j = 0; j < 4; j++) b[4*i + j] = b[4*(i-4) + j] ^ t[j];
        end
        for (int k = 0; k <= 10; k++)
            for (int n = 0; n < 16; n++) exp_rk[k][8*n +: 8] = b[16*k + n];
    endtask

    // ---------------- driver tasks ----------------
    task automatic read_slot(input logic [3:0] idx, output logic [127:0] d);
        bus.rk_rd_en  = 1'b1;
        bus.rk_rd_idx = idx;
        step();
        bus.rk_rd_en  = 1'b0;
        d = bus.rk_rd_data;
    endtask

    task automatic start_key(input string tag, input logic [127:0] key);
        chk_cnt++; if (bus.key_ready !== 1'b1) $display("FAIL %s key_ready_before_accept: got %b want 1", tag, bus.key_ready); else pass_cnt++;
        bus.key_valid = 1'b1;
        bus.key_in    = key;
        step();
        bus.key_valid = 1'b0;
        chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", tag, bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.keys_valid !== 1'b0) $display("FAIL %s keys_valid_after_accept: got %b want 0", tag, bus.keys_valid); else pass_cnt++;
    endtask

    // Called in the cycle after the accept edge; returns in the cycle after E10.
    task automatic wait_done(input string tag);
        for (int i = 1; i <= 10; i++) begin
            chk_cnt++;
            if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0 || bus.done !== 1'b0)
                $display("FAIL %s busy_phase[%0d]: got busy=%b ready=%b done=%b want 1/0/0", tag, i, bus.busy, bus.key_ready, bus.done);
            else pass_cnt++;
            rc_seen[i] = bus.dbg_rc;
            step();
        end
        chk_cnt++; if (bus.done !== 1'b1) $display("FAIL %s done_at_10: got %b want 1", tag, bus.done); else pass_cnt++;
        chk_cnt++; if (bus.keys_valid !== 1'b1) $display("FAIL %s keys_valid_at_done: got %b want 1", tag, bus.keys_valid); else pass_cnt++;
        chk_cnt++; if (bus.key_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL %s idle_at_done: got ready=%b busy=%b want 1/0", tag, bus.key_ready, bus.busy); else pass_cnt++;
    endtask

    task automatic check_slots(input string tag);
        logic [127:0] d;
        logic [127:0] e;
        for (int k = 0; k <= 10; k++) exp_q.push_back(exp_rk[k]);
        for (int k = 0; k <= 10; k++) begin
            read_slot(k[3:0], d);
            e = exp_q.pop_front();
            chk_cnt++; if (d !== e) $display("FAIL %s slot%0d: got %h want %h", tag, k, d, e); else pass_cnt++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        chk_cnt++; if (bus.key_ready !== 1'b1) $display("FAIL reset key_ready: got %b want 1", bus.key_ready); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else pass_cnt++;
        chk_cnt++; if (bus.keys_valid !== 1'b0) $display("FAIL reset keys_valid: got %b want 0", bus.keys_valid); else pass_cnt++;
        chk_cnt++; if (bus.rk_rd_data !== 128'h0) $display("FAIL reset rk_rd_data: got %h want 0", bus.rk_rd_data); else pass_cnt++;
        chk_cnt++; if (bus.dbg_round_cnt !== 4'd0) $display("FAIL reset round_cnt: got %0d want 0", bus.dbg_round_cnt); else pass_cnt++;
        chk_cnt++; if (bus.dbg_rc !== 8'h01) $display("FAIL reset rc: got %h want 01", bus.dbg_rc); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fips();
        logic [127:0] key;
        logic [127:0] d;
        key = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
        model_expand(key);
        start_key("fips", key);
        wait_done("fips");
        check_slots("fips");
        read_slot(4'd1, d);
        chk_cnt++; if (d !== bswap(128'ha0fafe1788542cb123a339392a6c7605)) $display("FAIL fips_kat slot1: got %h", d); else pass_cnt++;
        read_slot(4'd10, d);
        chk_cnt++; if (d !== bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) $display("FAIL fips_kat slot10: got %h", d); else pass_cnt++;
    endtask

    task automatic test_zero_key();
        logic [127:0] d;
        model_expand(128'h0);
        start_key("zero", 128'h0);
        wait_done("zero");
        for (int i = 1; i <= 10; i++) begin
            chk_cnt++; if (rc_seen[i] !== rcon_tab[i]) $display("FAIL zero rc[%0d]: got %h want %h", i, rc_seen[i], rcon_tab[i]); else pass_cnt++;
        end
        check_slots("zero");
        read_slot(4'd1, d);
        chk_cnt++; if (d !== bswap(128'h62636363626363636263636362636363)) $display("FAIL zero_kat slot1: got %h", d); else pass_cnt++;
        read_slot(4'd10, d);
        chk_cnt++; if (d !== bswap(128'hb4ef5bcb3e92e21123e951cf6f8f188e)) $display("FAIL zero_kat slot10: got %h", d); else pass_cnt++;
    endtask

    task automatic test_random_keys();
        logic [127:0] key;
        for (int n = 0; n < 3; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(key);
            start_key("random", key);
            wait_done("random");
            check_slots("random");
        end
    endtask

    task automatic test_ignore_busy();
        logic [127:0] ka;
        logic [127:0] kb;
        logic [127:0] a10;
        ka = {$urandom(), $urandom(), $urandom(), $urandom()};
        kb = ~ka;
        model_expand(ka);
        a10 = exp_rk[10];
        start_key("ignore", ka);
        bus.key_valid = 1'b1;
        bus.key_in    = kb;
        wait_done("ignore");
        bus.rk_rd_en  = 1'b1;
        bus.rk_rd_idx = 4'd10;
        step();
        bus.rk_rd_en  = 1'b0;
        bus.key_valid = 1'b0;
        chk_cnt++; if (bus.rk_rd_data !== a10) $display("FAIL ignore first_key_slot10: got %h want %h", bus.rk_rd_data, a10); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b1 || bus.keys_valid !== 1'b0) $display("FAIL ignore second_accept: got busy=%b kv=%b want 1/0", bus.busy, bus.keys_valid); else pass_cnt++;
        model_expand(kb);
        wait_done("ignore_b");
        check_slots("ignore_b");
    endtask

    task automatic test_reads();
        logic [127:0] key;
        logic [127:0] d;
        for (int k = 0; k <= 10; k++) prev_rk[k] = exp_rk[k];
        read_slot(4'd1, d);
        chk_cnt++; if (d !== prev_rk[1]) $display("FAIL reads slot1: got %h want %h", d, prev_rk[1]); else pass_cnt++;
        read_slot(4'd11, d);
        chk_cnt++; if (d !== 128'h0) $display("FAIL reads idx11: got %h want 0", d); else pass_cnt++;
        read_slot(4'd2, d);
        read_slot(4'd15, d);
        chk_cnt++; if (d !== 128'h0) $display("FAIL reads idx15: got %h want 0", d); else pass_cnt++;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        start_key("rbw", key);
        step();
        step();
        bus.rk_rd_en  = 1'b1;
        bus.rk_rd_idx = 4'd3;
        step();
        chk_cnt++; if (bus.rk_rd_data !== prev_rk[3]) $display("FAIL rbw stale: got %h want %h", bus.rk_rd_data, prev_rk[3]); else pass_cnt++;
        step();
        bus.rk_rd_en  = 1'b0;
        bus.rk_rd_idx = 4'd7;
        chk_cnt++; if (bus.rk_rd_data !== exp_rk[3]) $display("FAIL rbw fresh: got %h want %h", bus.rk_rd_data, exp_rk[3]); else pass_cnt++;
        for (int i = 5; i <= 10; i++) begin
            step();
            chk_cnt++; if (bus.rk_rd_data !== exp_rk[3]) $display("FAIL hold[%0d]: got %h want %h", i, bus.rk_rd_data, exp_rk[3]); else pass_cnt++;
        end
        chk_cnt++; if (bus.done !== 1'b1) $display("FAIL rbw done: got %b want 1", bus.done); else pass_cnt++;
        check_slots("rbw");
    endtask

    task automatic test_reset_mid();
        logic [127:0] key;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_key("rstmid", key);
        for (int i = 1; i <= 4; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_cnt++; if (bus.busy !== 1'b0 || bus.key_ready !== 1'b1) $display("FAIL rstmid state: got busy=%b ready=%b want 0/1", bus.busy, bus.key_ready); else pass_cnt++;
        chk_cnt++; if (bus.done !== 1'b0 || bus.keys_valid !== 1'b0) $display("FAIL rstmid flags: got done=%b kv=%b want 0/0", bus.done, bus.keys_valid); else pass_cnt++;
        chk_cnt++; if (bus.rk_rd_data !== 128'h0) $display("FAIL rstmid rd_data: got %h want 0", bus.rk_rd_data); else pass_cnt++;
        chk_cnt++; if (bus.dbg_round_cnt !== 4'd0 || bus.dbg_rc !== 8'h01) $display("FAIL rstmid counters: got cnt=%0d rc=%h want 0/01", bus.dbg_round_cnt, bus.dbg_rc); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            chk_cnt++; if (bus.keys_valid !== 1'b0 || bus.done !== 1'b0) $display("FAIL rstmid after[%0d]: got kv=%b done=%b want 0/0", i, bus.keys_valid, bus.done); else pass_cnt++;
        end
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(key);
        start_key("rstmid_new", key);
        wait_done("rstmid_new");
        check_slots("rstmid_new");
    endtask

    task automatic test_back_to_back();
        logic [127:0] key;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        start_key("b2b", key);
        for (int n = 0; n < 3; n++) begin
            wait_done("b2b");
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.key_valid = 1'b1;
            bus.key_in    = key;
            step();
            bus.key_valid = 1'b0;
            chk_cnt++; if (bus.done !== 1'b0) $display("FAIL b2b done_pulse[%0d]: got %b want 0", n, bus.done); else pass_cnt++;
            chk_cnt++; if (bus.keys_valid !== 1'b0 || bus.busy !== 1'b1) $display("FAIL b2b accept[%0d]: got kv=%b busy=%b want 0/1", n, bus.keys_valid, bus.busy); else pass_cnt++;
        end
        model_expand(key);
        wait_done("b2b_last");
        step();
        chk_cnt++; if (bus.done !== 1'b0) $display("FAIL b2b last_done_pulse: got %b want 0", bus.done); else pass_cnt++;
        check_slots("b2b_last");
    endtask

    // Scenario sequence and final report
    initial begin
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rk_rd_en  = 1'b0;
        bus.rk_rd_idx = '0;
        build_tables();
        test_reset();
        test_fips();
        test_zero_key();
        test_random_keys();
        test_ignore_busy();
        test_reads();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
